// File: rtl/inst_cache_dm_if.sv
// Core-side fetch port, refill port, flush control and statistics of the
// direct-mapped instruction cache, grouped into one bundle.
interface inst_cache_dm_if #(
    parameter int CNT_WIDTH = 16
);
    logic [29:0]          InstMem_Address;
    logic                 InstMem_Read;
    logic [31:0]          InstMem_In;
    logic                 InstMem_Ack;
    logic [29:0]          Mem_Address;
    logic                 Mem_Read;
    logic [31:0]          Mem_In;
    logic                 Mem_Ack;
    logic                 Flush;
    logic [CNT_WIDTH-1:0] Hit_Count;
    logic [CNT_WIDTH-1:0] Miss_Count;

    // Environment view: drives the core request, refill data and flush.
    modport master (
        output InstMem_Address, InstMem_Read, Mem_In, Mem_Ack, Flush,
        input  InstMem_In, InstMem_Ack, Mem_Address, Mem_Read, Hit_Count, Miss_Count
    );

    // Cache view.
    modport slave (
        input  InstMem_Address, InstMem_Read, Mem_In, Mem_Ack, Flush,
        output InstMem_In, InstMem_Ack, Mem_Address, Mem_Read, Hit_Count, Miss_Count
    );
endinterface

// File: rtl/inst_cache_dm.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line,
// single-word refill on miss, with wrap-around hit/miss counters.
module inst_cache_dm #(
    parameter int INDEX_BITS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic           clock,
    input  logic           reset,
    inst_cache_dm_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [31:0]          inst_in_q, inst_in_d;
    logic                 inst_ack_q, inst_ack_d;
    logic [29:0]          mem_addr_q, mem_addr_d;
    logic                 mem_read_q, mem_read_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic                 flush_pend_q, flush_pend_d;

    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [31:0]          data_q [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  req_hit;
    logic                  install_en;

    assign req_idx  = bus.InstMem_Address[INDEX_BITS-1:0];
    assign req_tag  = bus.InstMem_Address[29:INDEX_BITS];
    assign fill_idx = mem_addr_q[INDEX_BITS-1:0];
    assign fill_tag = mem_addr_q[29:INDEX_BITS];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Line payload carries no reset; the valid vector alone decides hits.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            always_ff @(posedge clock) begin
                if (install_en && (fill_idx == INDEX_BITS'(gi))) begin
                    tag_q[gi]  <= fill_tag;
                    data_q[gi] <= bus.Mem_In;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        inst_in_d    = inst_in_q;
        inst_ack_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_read_d   = mem_read_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        flush_pend_d = flush_pend_q;
        install_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Flush) begin
                    valid_d = '0;
                end else if (bus.InstMem_Read) begin
                    if (req_hit) begin
                        inst_in_d  = data_q[req_idx];
                        inst_ack_d = 1'b1;
                        hit_cnt_d  = hit_cnt_q + 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        mem_addr_d = bus.InstMem_Address;
                        mem_read_d = 1'b1;
                        miss_cnt_d = miss_cnt_q + 1'b1;
                        state_d    = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (bus.Flush) begin
                    flush_pend_d = 1'b1;
                    valid_d      = '0;
                end
                if (bus.Mem_Ack) begin
                    mem_read_d   = 1'b0;
                    inst_in_d    = bus.Mem_In;
                    inst_ack_d   = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = S_RESP;
                    // A flush seen at any point of this refill keeps the word out of the array.
                    if (!flush_pend_q && !bus.Flush) begin
                        install_en        = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (bus.Flush) begin
                    valid_d = '0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            inst_in_q    <= '0;
            inst_ack_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            inst_in_q    <= inst_in_d;
            inst_ack_q   <= inst_ack_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus.InstMem_In  = inst_in_q;
    assign bus.InstMem_Ack = inst_ack_q;
    assign bus.Mem_Address = mem_addr_q;
    assign bus.Mem_Read    = mem_read_q;
    assign bus.Hit_Count   = hit_cnt_q;
    assign bus.Miss_Count  = miss_cnt_q;
endmodule

// File: tb/tb_inst_cache_dm.sv
// Directed bench for inst_cache_dm: a line-level cache model predicts every
// registered output each cycle; literal expectations pin the model per scenario.
module tb_inst_cache_dm;
    logic clock;
    logic reset;

    inst_cache_dm_if #(.CNT_WIDTH(16)) bus ();

    inst_cache_dm #(
        .INDEX_BITS(3),
        .CNT_WIDTH (16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Cache model: what each of the 8 lines holds, plus the counters.
    logic [7:0]  m_valid;
    logic [26:0] m_tag  [8];
    logic [31:0] m_data [8];
    int          m_hits;
    int          m_miss;

    // Expected DUT outputs for the cycle following the next rising edge.
    logic        cmp_en;
    logic        exp_ack;
    logic [31:0] exp_in;
    logic        exp_mem_read;
    logic [29:0] exp_mem_addr;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
    logic        prev_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h0FF8) return 32'h20130003;
        return {a[15:0], ~a[15:0]} ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clock) begin
        #2;
        if (cmp_en) begin
            check("inst_ack", {31'd0, bus.InstMem_Ack}, {31'd0, exp_ack});
            check("inst_in", bus.InstMem_In, exp_in);
            check("mem_read", {31'd0, bus.Mem_Read}, {31'd0, exp_mem_read});
            check("mem_addr", {2'd0, bus.Mem_Address}, {2'd0, exp_mem_addr});
            check("hit_count", {16'd0, bus.Hit_Count}, {16'd0, exp_hit});
            check("miss_count", {16'd0, bus.Miss_Count}, {16'd0, exp_miss});
            check("ack_back_to_back", {31'd0, prev_ack & bus.InstMem_Ack}, 32'd0);
            prev_ack = bus.InstMem_Ack;
        end
    end

    task automatic model_reset();
        m_valid      = '0;
        m_hits       = 0;
        m_miss       = 0;
        exp_ack      = 1'b0;
        exp_in       = '0;
        exp_mem_read = 1'b0;
        exp_mem_addr = '0;
        exp_hit      = '0;
        exp_miss     = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        $display("reset applied");
    endtask

    // One core fetch; delay = cycles Mem_Read is held before Mem_Ack (>=1).
    task automatic fetch(input logic [29:0] a, input int delay, input bit flush_fill);
        logic [2:0]  idx = a[2:0];
        logic [26:0] tg  = a[29:3];
        logic [31:0] w;
        bit          hit = m_valid[idx] && (m_tag[idx] == tg);
        bus.InstMem_Address = a;
        bus.InstMem_Read    = 1'b1;
        if (hit) begin
            m_hits++;
            exp_hit = 16'(m_hits);
            exp_ack = 1'b1;
            exp_in  = m_data[idx];
            @(negedge clock);
            bus.InstMem_Read    = 1'b0;
            bus.InstMem_Address = ~a;
            exp_ack             = 1'b0;
        end else begin
            w = mem_word(a);
            m_miss++;
            exp_miss     = 16'(m_miss);
            exp_mem_read = 1'b1;
            exp_mem_addr = a;
            @(negedge clock);
            bus.InstMem_Read    = 1'b0;
            bus.InstMem_Address = a ^ 30'h155;
            for (int i = 1; i < delay; i++) begin
                if (flush_fill && i == 1) begin
                    bus.Flush = 1'b1;
                    m_valid   = '0;
                end
                @(negedge clock);
                bus.Flush = 1'b0;
            end
            bus.Mem_Ack  = 1'b1;
            bus.Mem_In   = w;
            exp_mem_read = 1'b0;
            exp_ack      = 1'b1;
            exp_in       = w;
            if (!flush_fill) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = w;
            end
            @(negedge clock);
            bus.Mem_Ack = 1'b0;
            bus.Mem_In  = $urandom;
            exp_ack     = 1'b0;
        end
        @(negedge clock);
        $display("fetch addr=%h %s data=%h hits=%0d misses=%0d", a, hit ? "hit " : "miss",
                 exp_in, m_hits, m_miss);
    endtask

    initial begin
        cmp_en              = 1'b0;
        prev_ack            = 1'b0;
        reset               = 1'b1;
        bus.InstMem_Address = '0;
        bus.InstMem_Read    = 1'b0;
        bus.Mem_In          = '0;
        bus.Mem_Ack         = 1'b0;
        bus.Flush           = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_tag[i]  = '0;
            m_data[i] = '0;
        end
        model_reset();
        repeat (2) @(negedge clock);
        cmp_en = 1'b1;
        apply_reset();

        // 1: cold miss with a three-cycle refill
        fetch(30'h0FF8, 3, 1'b0);
        check("t1_inst_in", bus.InstMem_In, 32'h20130003);
        check("t1_miss", {16'd0, bus.Miss_Count}, 32'd1);

        // 2: same address now hits
        fetch(30'h0FF8, 1, 1'b0);
        check("t2_hit", {16'd0, bus.Hit_Count}, 32'd1);
        check("t2_inst_in", bus.InstMem_In, 32'h20130003);

        // 3: conflict on index 0
        apply_reset();
        fetch(30'h0FF8, 2, 1'b0);
        fetch(30'h1000, 2, 1'b0);
        check("t3_refill_addr", {2'd0, bus.Mem_Address}, 32'h1000);
        fetch(30'h0FF8, 2, 1'b0);
        check("t3_miss", {16'd0, bus.Miss_Count}, 32'd3);
        check("t3_hit", {16'd0, bus.Hit_Count}, 32'd0);

        // 4: nine-word loop twice; 0x0FF8 and 0x1000 keep evicting each other
        apply_reset();
        for (int pass = 0; pass < 2; pass++)
            for (int a = 'h0FF8; a <= 'h1000; a++)
                fetch(30'(a), 1 + (a % 3), 1'b0);
        check("t4_model_hits", m_hits, 32'd7);
        check("t4_hit", {16'd0, bus.Hit_Count}, 32'd7);
        check("t4_miss", {16'd0, bus.Miss_Count}, 32'd11);

        // 5: flush during a refill, then flush request rejection in idle
        apply_reset();
        fetch(30'h0FFA, 1, 1'b0);
        fetch(30'h0FFA, 1, 1'b0);
        fetch(30'h0FF9, 3, 1'b1);
        check("t5_flush_data", bus.InstMem_In, mem_word(30'h0FF9));
        fetch(30'h0FF9, 2, 1'b0);
        fetch(30'h0FFA, 2, 1'b0);
        check("t5_miss", {16'd0, bus.Miss_Count}, 32'd4);
        check("t5_hit", {16'd0, bus.Hit_Count}, 32'd1);
        fetch(30'h0FFB, 1, 1'b0);
        bus.InstMem_Address = 30'h0FFB;
        bus.InstMem_Read    = 1'b1;
        bus.Flush           = 1'b1;
        m_valid             = '0;
        @(negedge clock);
        bus.InstMem_Read = 1'b0;
        bus.Flush        = 1'b0;
        @(negedge clock);
        $display("flush with request addr=0FFB (not accepted)");
        fetch(30'h0FFB, 1, 1'b0);
        check("t5_flush_idle_miss", {16'd0, bus.Miss_Count}, 32'd6);

        // 6: reset during a refill, then a stray Mem_Ack
        apply_reset();
        fetch(30'h0FFC, 1, 1'b0);
        bus.InstMem_Address = 30'h0FFD;
        bus.InstMem_Read    = 1'b1;
        m_miss++;
        exp_miss     = 16'(m_miss);
        exp_mem_read = 1'b1;
        exp_mem_addr = 30'h0FFD;
        @(negedge clock);
        bus.InstMem_Read = 1'b0;
        @(negedge clock);
        apply_reset();
        bus.Mem_Ack = 1'b1;
        bus.Mem_In  = 32'hDEAD_BEEF;
        @(negedge clock);
        bus.Mem_Ack = 1'b0;
        @(negedge clock);
        $display("late Mem_Ack after reset mid-fill");
        check("t6_mem_read", {31'd0, bus.Mem_Read}, 32'd0);
        check("t6_miss", {16'd0, bus.Miss_Count}, 32'd0);
        check("t6_inst_in", bus.InstMem_In, 32'd0);
        fetch(30'h0FFC, 1, 1'b0);
        check("t6_invalid_after_reset", {16'd0, bus.Miss_Count}, 32'd1);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
